// File: rtl/lock_ctrl_if.sv
// Keypad-side bundle of lock_ctrl: key code and strobe in, lock status out.
// strobe is a level, synchronous to clk. The rising edge is the only event:
// there is no ready, and key must be valid on the first edge that samples strobe high.
interface lock_ctrl_if;
  logic [4:0] key;
  logic       strobe;
  logic       unlock;
  logic       alarm;
  logic [1:0] state;
  logic [2:0] entry_cnt;
  logic [2:0] fail_cnt;

  modport master (
    output key, strobe,
    input  unlock, alarm, state, entry_cnt, fail_cnt
  );

  modport slave (
    input  key, strobe,
    output unlock, alarm, state, entry_cnt, fail_cnt
  );
endinterface

// File: rtl/lock_ctrl.sv
// Combination-lock controller: digit entry, compare, combination change, optional lockout.
// Define LOCKOUT_EN to build the timed LOCKOUT state, its down-counter and the alarm output.
module lock_ctrl #(
  parameter int                     CODE_LEN       = 4,
  parameter int                     MAX_FAIL       = 3,
  parameter int                     LOCKOUT_CYCLES = 5000,
  parameter logic [CODE_LEN*4-1:0]  RESET_COMBO    = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  lock_ctrl_if.slave bus
);
  localparam int         W    = CODE_LEN * 4;
  localparam logic [2:0] LAST = 3'(CODE_LEN - 1);
  localparam logic [2:0] FULL = 3'(CODE_LEN);

  typedef enum logic [1:0] {
    LOCKED  = 2'b00,
    ENTRY   = 2'b01,
    OPEN    = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   entry_buf_q, entry_buf_d;
  logic [W-1:0]   combo_q, combo_d;
  logic [W-1:0]   shifted;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     fail_q, fail_d;
  logic [2:0]     fail_inc;
  logic           strobe_q;
  logic           unlock_q;
  logic           press, is_digit, is_f, last_digit, match, lockout_hit;

  assign press      = bus.strobe & ~strobe_q;
  assign is_digit   = ~bus.key[4];
  assign is_f       = (bus.key == 5'd16);
  assign last_digit = (cnt_q == LAST);
  assign fail_inc   = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
  assign match      = (shifted == combo_q);

  if (CODE_LEN == 1) begin : g_one
    assign shifted = bus.key[3:0];
  end else begin : g_multi
    assign shifted = {entry_buf_q[W-5:0], bus.key[3:0]};
  end

`ifdef LOCKOUT_EN
  localparam int            CW        = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [2:0]    MAXF      = 3'(MAX_FAIL);

  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          alarm_q;

  assign lockout_hit = ~match & (fail_inc == MAXF);
  assign bus.alarm   = alarm_q;
`else
  assign lockout_hit = 1'b0;
  assign bus.alarm   = 1'b0;
`endif

  assign bus.unlock    = unlock_q;
  assign bus.state     = state_q;
  assign bus.entry_cnt = cnt_q;
  assign bus.fail_cnt  = fail_q;

  // State and datapath registers; unlock/alarm are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOCKED;
      entry_buf_q <= '0;
      combo_q     <= RESET_COMBO;
      cnt_q       <= '0;
      fail_q      <= '0;
      strobe_q    <= 1'b0;
      unlock_q    <= 1'b0;
`ifdef LOCKOUT_EN
      lock_cnt_q  <= '0;
      alarm_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      entry_buf_q <= entry_buf_d;
      combo_q     <= combo_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      strobe_q    <= bus.strobe;
      unlock_q    <= (state_d == OPEN);
`ifdef LOCKOUT_EN
      lock_cnt_q  <= lock_cnt_d;
      alarm_q     <= (state_d == LOCKOUT);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOCKED, ENTRY: begin
        if (press && is_digit) begin
          if (!last_digit)      state_d = ENTRY;
          else if (match)       state_d = OPEN;
          else if (lockout_hit) state_d = LOCKOUT;
          else                  state_d = LOCKED;
        end else if (press && is_f) begin
          state_d = LOCKED;
        end
      end
      OPEN: begin
        if (press && is_f && (cnt_q == 3'd0 || cnt_q == FULL)) state_d = LOCKED;
      end
      default: begin
`ifdef LOCKOUT_EN
        if (lock_cnt_q == '0) state_d = LOCKED;
`endif
      end
    endcase
  end

  always_comb begin
    entry_buf_d = entry_buf_q;
    combo_d     = combo_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
`ifdef LOCKOUT_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    case (state_q)
      LOCKED, ENTRY: begin
        if (press && is_digit) begin
          if (last_digit) begin
            entry_buf_d = '0;
            cnt_d       = '0;
            fail_d      = match ? 3'd0 : fail_inc;
`ifdef LOCKOUT_EN
            if (lockout_hit) lock_cnt_d = LOCK_LOAD;
`endif
          end else begin
            entry_buf_d = shifted;
            cnt_d       = cnt_q + 3'd1;
          end
        end else if (press && is_f) begin
          entry_buf_d = '0;
          cnt_d       = '0;
        end
      end
      OPEN: begin
        if (press && is_digit && cnt_q < FULL) begin
          entry_buf_d = shifted;
          cnt_d       = cnt_q + 3'd1;
        end else if (press && is_f) begin
          if (cnt_q == FULL) combo_d = entry_buf_q;
          entry_buf_d = '0;
          cnt_d       = '0;
        end
      end
      default: begin
`ifdef LOCKOUT_EN
        if (lock_cnt_q == '0) begin
          fail_d      = '0;
          cnt_d       = '0;
          entry_buf_d = '0;
        end else begin
          lock_cnt_d  = lock_cnt_q - ONE;
        end
`endif
      end
    endcase
  end
endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Combination-lock controller that sits directly downstream of the keypad synchroniser. It consumes the 5-bit key code and the synchronised key strobe, and collects hex digits into an entry buffer. It compares each completed entry against a stored combination and drives the unlock and alarm outputs. While open, the combination can be changed from the keypad; repeated failures can force a timed lockout.

## Interface
- CODE_LEN, 4: digits per combination; legal range 1..7.
- MAX_FAIL, 3: consecutive mismatches that trigger lockout; legal range 1..7.
- LOCKOUT_CYCLES, 5000: clk cycles spent in LOCKOUT; must be ≥ 1.
- RESET_COMBO, 16'h1234: combination after reset, CODE_LEN×4 bits, first digit in the MS nibble.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- key  in  5  key code; 0..15 = hex digit, 16 = function key (F), 17..31 ignored.
- strobe  in  1  synchronised key-held level, synchronous to clk.
- unlock  out  1  high in OPEN.
- alarm  out  1  high in LOCKOUT.
- state  out  2  00 LOCKED, 01 ENTRY, 10 OPEN, 11 LOCKOUT.
- entry_cnt  out  3  digits currently buffered.
- fail_cnt  out  3  consecutive mismatches.

## Operation
- Press detection: internal strobe_q <= strobe. press = strobe & ~strobe_q. Exactly one press per strobe rising edge, however long strobe stays high.
- key is sampled only when press = 1. key is ignored at all other times and in LOCKOUT.
- LOCKED: digit d stores d, sets entry_cnt = 1, goes to ENTRY. With CODE_LEN = 1, LOCKED performs the ENTRY compare on the first digit instead. F leaves everything unchanged.
- ENTRY, digit d with entry_cnt < CODE_LEN−1: shift d into the buffer and increment entry_cnt.
- ENTRY, digit d with entry_cnt = CODE_LEN−1: compare {buffer, d} against the stored combination, then clear the buffer and set entry_cnt = 0.
  - Match: go to OPEN and set fail_cnt = 0.
  - Mismatch: fail_cnt+1. Go to LOCKOUT if the new value = MAX_FAIL and LOCKOUT_EN is defined; otherwise go to LOCKED.
- ENTRY, F: clear the buffer and set entry_cnt = 0. Go to LOCKED. fail_cnt is unchanged.
- OPEN, digit: shift into the buffer and increment entry_cnt. Digits beyond CODE_LEN are dropped and entry_cnt holds at CODE_LEN.
- OPEN, F, with entry_cnt = 0: go to LOCKED with the combination unchanged.
- OPEN, F, with entry_cnt = CODE_LEN: the buffer becomes the new combination. Clear the buffer and go to LOCKED.
- OPEN, F, with any other entry_cnt: clear the buffer and stay in OPEN.
- LOCKOUT: down-counter is loaded with LOCKOUT_CYCLES−1 on entry and decrements each clk. At count 0 the next edge goes to LOCKED with fail_cnt = 0 and entry_cnt = 0.
- fail_cnt saturates at 7.
- Compare is a full-width equality on CODE_LEN×4 bits. Buffer shift is {buf[CODE_LEN*4-5:0], d[3:0]}.

## Timing
- Reset values:
  - unlock = 0, alarm = 0, state = 00, entry_cnt = 0, fail_cnt = 0.
  - Combination = RESET_COMBO; strobe_q = 0; lockout counter = 0.
- All outputs are registered.
- Latency: outputs update on the first clk edge that samples strobe = 1 after strobe was 0 (1 edge after the strobe rise).
- A strobe rising at reset deassertion counts as a press on the first edge with strobe = 1.
- Back-to-back presses need strobe low for ≥ 1 sampled edge between them.
- rst mid-operation (any state, including a partial entry or lockout) returns every register to its reset value. A combination changed at run time reverts to RESET_COMBO.
- LOCKOUT duration: alarm is high for exactly LOCKOUT_CYCLES edges.
- A press arriving on the exit edge of LOCKOUT is ignored.

## Configuration
- LOCKOUT_EN defined: the LOCKOUT state, counter and alarm are implemented as above.
- LOCKOUT_EN undefined:
  - The counter is not built and alarm is tied 0.
  - Reaching MAX_FAIL goes to LOCKED. fail_cnt keeps counting, saturating at 7, and clears only on a match or reset.

## Test plan
- Correct code: after reset, press 1,2,3,4 → state 01 after "1", entry_cnt 1,2,3; 1 edge after the "4" strobe rise: unlock = 1, state = 10, fail_cnt = 0.
- Held key: strobe high for 50 cycles on key 5 → exactly one digit is accepted (entry_cnt = 1).
- Abort entry: press 1,2 then F (key 16) → state = 00, entry_cnt = 0, fail_cnt = 0.
- Lockout (LOCKOUT_EN, LOCKOUT_CYCLES = 10):
  - Enter 0000 three times → fail_cnt 1, 2, then 3 and state = 11 with alarm = 1 for exactly 10 cycles.
  - Presses during the alarm are ignored.
  - Afterwards state = 00 and fail_cnt = 0.
- Change combination: open with 1234, press 9,8,7,6,F → state = 00. Then 1234 → fail_cnt = 1, and 9876 → unlock = 1.
- Async reset mid-lockout: assert rst between clk edges → all outputs are 0 immediately and the combination is 1234 again.
